addr_port_arbiter: RTL and testbench
====================================

# addr_port_arbiter

Arbitrates up to NREQ requesters (fetch, load/store, stack, DMA) onto the two write ports (A and B) of the dual-port address register. Each port has its own grant state machine with a round-robin pointer. A requester may lock a port for multi-cycle ownership. The block drives the address register's addrInA/wrenA and addrInB/wrenB directly and returns one-hot grants to the requesters.

## Interface
- NREQ, 4: number of requesters (2..8)
- AW, 16: address width
- MAXHOLD, 8: maximum consecutive owned cycles per grant (timeout build only)

- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- req  in  NREQ  request to write an address this cycle
- lock  in  NREQ  keep current port ownership after this cycle
- addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
- gntA  out  NREQ  one-hot (or zero) owner of port A, registered
- gntB  out  NREQ  one-hot (or zero) owner of port B, registered
- addrInA  out  AW  address for port A
- wrenA  out  1  write enable for port A
- addrInB  out  AW  address for port B
- wrenB  out  1  write enable for port B
- busy  out  1  either port owned

## Operation
- Per port FSM with two states:
  - IDLE: no owner.
  - OWNED: one owner index held in a register.
- Arbitration happens each cycle for a port that is:
  - in IDLE, or
  - in OWNED with lock[owner]=0, or
  - in OWNED with the timeout reached.
- Candidate set is req, minus any requester that owns the other port, or will own it next cycle.
- Port A arbitrates first. Port B excludes A's resulting next owner.
- Round-robin order: search from ptrX upward, modulo NREQ. The first candidate wins.
  - On a win by i: ptrX <= (i+1) mod NREQ.
  - With no candidate: the port goes to IDLE and ptrX is unchanged.
- Release with a simultaneous request is back-to-back: the new owner is granted on the next edge, with no idle bubble.
- The outgoing owner competes normally, but the pointer has already advanced past it.
- If lock[owner]=1 and req[owner]=0, the owner keeps the port with wrenX=0.
- A requester never owns both ports at once.
- wrenX = OWNED & req[ownerX].
- addrInX = addr[ownerX] when OWNED, else 0. Both are combinational from the registered owner.
- busy = OWNED_A | OWNED_B.

## Timing
- Reset (reset_n=0 at an edge) produces:
  - gntA=gntB=0, wrenA=wrenB=0, addrInA=addrInB=0, busy=0.
  - ptrA=ptrB=0, hold counters 0, both FSMs IDLE.
- Reset mid-ownership drops grants at that edge, and no write is issued afterwards.
- Grant latency: req high in cycle t gives gnt high in cycle t+1. In t+1, wren and addrIn reflect that requester's addr in cycle t+1.
- Minimum ownership is 1 cycle.
- lock is sampled at the end of each owned cycle. lock=0 in the first owned cycle produces a single-cycle grant.
- Simultaneous release of A and grant request on B: the released A owner is eligible for B in the same arbitration.

## Configuration
- ADDR_ARB_TIMEOUT_EN
  - Defined:
    - A per-port counter counts owned cycles and resets on each new grant.
    - When the counter reaches MAXHOLD, the port arbitrates regardless of lock. The forced-out owner is excluded from that port's candidate set for that one arbitration.
    - The counter width is clog2(MAXHOLD+1).
  - Undefined:
    - No counters exist. Ownership lasts until lock drops, with unbounded hold.

## Structure
- Package addr_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_OWNED);
  - the default NREQ/AW/MAXHOLD constants;
  - an index-width function clog2.
- One sub-module, rr_pick: a combinational round-robin picker with:
  - inputs cand[NREQ] and ptr;
  - outputs valid and idx.
- rr_pick is instantiated once per port. Port A's result feeds port B's mask.

## Test plan
- Reset then idle:
  - reset_n=0 for 2 cycles, req=0 -> all outputs 0, busy=0.
  - Hold reset_n=0 while req=4'b1111 -> grants stay 0.
- Single requester:
  - req[2]=1 with addr2=16'h1234 at t -> gntA=4'b0100, wrenA=1, addrInA=16'h1234 at t+1; gntB=0.
- Two-port split and round robin:
  - req=4'b1111, lock=0 continuously -> grant pairs (A,B) over successive cycles are (0,1), (2,3), (0,1), ...
  - No requester is granted on both ports in any cycle.
- Lock hold with no request:
  - Requester 1 owns A, then lock[1]=1, req[1]=0 for 3 cycles -> gntA=4'b0010, wrenA=0 throughout; other requesters go to B only.
  - Then lock[1]=0 with req[3]=1 -> next edge gntA=4'b1000.
- Timeout (ADDR_ARB_TIMEOUT_EN, MAXHOLD=8):
  - Requester 0 holds lock=1, req=1; requester 2 requests; B is kept busy by requester 3 with lock=1.
  - -> A is forced to requester 2 after exactly 8 owned cycles.
  - Without the macro, requester 0 keeps A indefinitely.
- Reset mid-ownership:
  - Both ports owned, reset_n=0 for one edge -> next cycle gntA=gntB=0, wrenA=wrenB=0, and ptrs restart at 0 (req=4'b1111 gives A=0, B=1).

Source files
------------

// File: rtl/addr_arb_pkg.sv
// addr_arb_pkg: shared types and constants for the address register write-port arbiter.
// Holds the per-port FSM state enum, default sizing constants and an index-width helper.
package addr_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

   localparam int NREQ_DEF    = 4;
   localparam int AW_DEF      = 16;
   localparam int MAXHOLD_DEF = 8;

   // Bits needed to index v distinct values; never less than 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/addr_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: cand_i (candidate mask), ptr_i (search start) -> valid_o (any candidate), idx_o (winner).
module rr_pick
   import addr_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]        cand_i,
   input  logic [clog2(NREQ)-1:0] ptr_i,
   output logic                   valid_o,
   output logic [clog2(NREQ)-1:0] idx_o
);

   localparam int IW = clog2(NREQ);

   always_comb begin
      int j;
      valid_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NREQ) begin
            j = j - NREQ;
         end
         if (!valid_o && cand_i[j]) begin
            valid_o = 1'b1;
            idx_o   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/addr_port_arbiter.sv
// addr_port_arbiter: grants NREQ requesters onto write ports A and B of the address register.
// Inputs: clock_i, reset_n_i (sync, active low), req_i, lock_i, addr_i (flattened, AW per requester).
// Outputs: gntA_o/gntB_o (registered one-hot owners), addrInA_o/wrenA_o, addrInB_o/wrenB_o, busy_o.
// Build option ADDR_ARB_TIMEOUT_EN: force re-arbitration after MAXHOLD owned cycles.
module addr_port_arbiter
   import addr_arb_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int AW      = AW_DEF,
   parameter int MAXHOLD = MAXHOLD_DEF
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic [NREQ-1:0]  req_i,
   input  logic [NREQ-1:0]  lock_i,
   input  logic [NREQ*AW-1:0] addr_i,
   output logic [NREQ-1:0]  gntA_o,
   output logic [NREQ-1:0]  gntB_o,
   output logic [AW-1:0]    addrInA_o,
   output logic             wrenA_o,
   output logic [AW-1:0]    addrInB_o,
   output logic             wrenB_o,
   output logic             busy_o
);

   localparam int IW = clog2(NREQ);
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   arb_state_e      st_a_q, st_a_d;
   arb_state_e      st_b_q, st_b_d;
   logic [IW-1:0]   own_a_q, own_a_d;
   logic [IW-1:0]   own_b_q, own_b_d;
   logic [IW-1:0]   ptr_a_q, ptr_a_d;
   logic [IW-1:0]   ptr_b_q, ptr_b_d;
   logic [NREQ-1:0] gnt_a_q, gnt_a_d;
   logic [NREQ-1:0] gnt_b_q, gnt_b_d;

   logic            own_a, own_b;
   logic            arb_a, arb_b;
   logic            tmo_a, tmo_b;
   logic            new_a, new_b;
   logic            val_a, val_b;
   logic [IW-1:0]   idx_a, idx_b;
   logic [NREQ-1:0] cand_a, cand_b;

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] i);
      return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
   endfunction

   assign own_a = (st_a_q == ARB_OWNED);
   assign own_b = (st_b_q == ARB_OWNED);

   assign arb_a = !own_a || !lock_i[own_a_q] || tmo_a;
   assign arb_b = !own_b || !lock_i[own_b_q] || tmo_b;

   // A must skip B's current owner; a timed-out owner sits out one round.
   always_comb begin
      cand_a = req_i;
      if (own_b) begin
         cand_a = cand_a & ~(ONE << own_b_q);
      end
      if (tmo_a) begin
         cand_a = cand_a & ~(ONE << own_a_q);
      end
   end

   rr_pick #(.NREQ(NREQ)) u_pick_a (
      .cand_i  (cand_a),
      .ptr_i   (ptr_a_q),
      .valid_o (val_a),
      .idx_o   (idx_a)
   );

   always_comb begin
      st_a_d  = st_a_q;
      own_a_d = own_a_q;
      ptr_a_d = ptr_a_q;
      new_a   = 1'b0;
      if (arb_a) begin
         if (val_a) begin
            st_a_d  = ARB_OWNED;
            own_a_d = idx_a;
            ptr_a_d = ptr_inc(idx_a);
            new_a   = 1'b1;
         end else begin
            st_a_d = ARB_IDLE;
         end
      end
      gnt_a_d = (st_a_d == ARB_OWNED) ? (ONE << own_a_d) : '0;
   end

   // B only has to avoid A's next owner; A's outgoing owner stays eligible.
   always_comb begin
      cand_b = req_i & ~gnt_a_d;
      if (tmo_b) begin
         cand_b = cand_b & ~(ONE << own_b_q);
      end
   end

   rr_pick #(.NREQ(NREQ)) u_pick_b (
      .cand_i  (cand_b),
      .ptr_i   (ptr_b_q),
      .valid_o (val_b),
      .idx_o   (idx_b)
   );

   always_comb begin
      st_b_d  = st_b_q;
      own_b_d = own_b_q;
      ptr_b_d = ptr_b_q;
      new_b   = 1'b0;
      if (arb_b) begin
         if (val_b) begin
            st_b_d  = ARB_OWNED;
            own_b_d = idx_b;
            ptr_b_d = ptr_inc(idx_b);
            new_b   = 1'b1;
         end else begin
            st_b_d = ARB_IDLE;
         end
      end
      gnt_b_d = (st_b_d == ARB_OWNED) ? (ONE << own_b_d) : '0;
   end

`ifdef ADDR_ARB_TIMEOUT_EN
   localparam int CW = clog2(MAXHOLD + 1);

   logic [CW-1:0] cnt_a_q, cnt_a_d;
   logic [CW-1:0] cnt_b_q, cnt_b_d;

   assign tmo_a = own_a && (cnt_a_q == CW'(MAXHOLD));
   assign tmo_b = own_b && (cnt_b_q == CW'(MAXHOLD));

   // Counter holds the number of owned cycles so far, including the current one.
   always_comb begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      if (st_a_d == ARB_OWNED) begin
         cnt_a_d = new_a ? CW'(1) : cnt_a_q + 1'b1;
      end
      if (st_b_d == ARB_OWNED) begin
         cnt_b_d = new_b ? CW'(1) : cnt_b_q + 1'b1;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end
`else
   logic [31:0] unused_maxhold;
   logic        unused_new;

   assign unused_maxhold = 32'(MAXHOLD);
   assign unused_new     = new_a ^ new_b;
   assign tmo_a          = 1'b0;
   assign tmo_b          = 1'b0;
`endif

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         st_a_q  <= ARB_IDLE;
         st_b_q  <= ARB_IDLE;
         own_a_q <= '0;
         own_b_q <= '0;
         ptr_a_q <= '0;
         ptr_b_q <= '0;
         gnt_a_q <= '0;
         gnt_b_q <= '0;
      end else begin
         st_a_q  <= st_a_d;
         st_b_q  <= st_b_d;
         own_a_q <= own_a_d;
         own_b_q <= own_b_d;
         ptr_a_q <= ptr_a_d;
         ptr_b_q <= ptr_b_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
      end
   end

   assign gntA_o    = gnt_a_q;
   assign gntB_o    = gnt_b_q;
   assign wrenA_o   = own_a && req_i[own_a_q];
   assign wrenB_o   = own_b && req_i[own_b_q];
   assign addrInA_o = own_a ? addr_i[own_a_q*AW +: AW] : '0;
   assign addrInB_o = own_b ? addr_i[own_b_q*AW +: AW] : '0;
   assign busy_o    = own_a || own_b;

endmodule

// File: tb/tb_addr_port_arbiter.sv
// tb_addr_port_arbiter: vector table, hand sequences and random traffic
// checked against a queue-free ownership model of the two write ports.
module tb_addr_port_arbiter;

   localparam int NREQ    = 4;
   localparam int AW      = 16;
   localparam int MAXHOLD = 8;
`ifdef ADDR_ARB_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  lock;
   logic [AW-1:0]    am [NREQ];
   logic [NREQ*AW-1:0] addr;
   logic [NREQ-1:0]  gntA, gntB;
   logic [AW-1:0]    addrInA, addrInB;
   logic             wrenA, wrenB, busy;
   logic [42:0]      dut_v;

   int nvec;
   int nbad;

   // Model: owner per port (-1 = idle), round-robin pointer, owned-cycle count.
   int mo [2];
   int mp [2];
   int mh [2];

   typedef struct {
      bit              rst;
      logic [NREQ-1:0] rq;
      logic [NREQ-1:0] lk;
      logic [NREQ-1:0] ga;
      logic [NREQ-1:0] gb;
      bit              wa;
      bit              wb;
      logic [AW-1:0]   aa;
      logic [AW-1:0]   ab;
   } vec_t;

   vec_t tab [18];

   assign addr  = {am[3], am[2], am[1], am[0]};
   assign dut_v = {gntA, gntB, wrenA, wrenB, addrInA, addrInB, busy};

   addr_port_arbiter #(
      .NREQ(NREQ), .AW(AW), .MAXHOLD(MAXHOLD)
   ) dut (
      .clock_i   (clk),
      .reset_n_i (rst_n),
      .req_i     (req),
      .lock_i    (lock),
      .addr_i    (addr),
      .gntA_o    (gntA),
      .gntB_o    (gntB),
      .addrInA_o (addrInA),
      .wrenA_o   (wrenA),
      .addrInB_o (addrInB),
      .wrenB_o   (wrenB),
      .busy_o    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [42:0] act, input logic [42:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic arb(input int p, input int other);
      bit forced;
      int win;
      forced = 1'b0;
      win    = -1;
      if (mo[p] >= 0) begin
         forced = TMO_ON && (mh[p] >= MAXHOLD);
         if (lock[mo[p]] && !forced) begin
            mh[p]++;
            return;
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (mp[p] + k) % NREQ;
         if (win < 0 && req[i] && i != other && !(forced && i == mo[p]))
            win = i;
      end
      if (win >= 0) begin
         mo[p] = win;
         mp[p] = (win + 1) % NREQ;
         mh[p] = 1;
      end else begin
         mo[p] = -1;
         mh[p] = 0;
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         for (int p = 0; p < 2; p++) begin
            mo[p] = -1;
            mp[p] = 0;
            mh[p] = 0;
         end
      end else begin
         arb(0, mo[1]);
         arb(1, mo[0]);
      end
   endtask

   function automatic logic [42:0] model_out();
      logic [NREQ-1:0] ga, gb;
      logic            wa, wb;
      logic [AW-1:0]   aa, ab;
      ga = '0; gb = '0; wa = 1'b0; wb = 1'b0; aa = '0; ab = '0;
      if (mo[0] >= 0) begin
         ga[mo[0]] = 1'b1;
         wa = req[mo[0]];
         aa = am[mo[0]];
      end
      if (mo[1] >= 0) begin
         gb[mo[1]] = 1'b1;
         wb = req[mo[1]];
         ab = am[mo[1]];
      end
      return {ga, gb, wa, wb, aa, ab, (mo[0] >= 0) || (mo[1] >= 0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      nvec  = 0;
      nbad  = 0;
      rst_n = 1'b0;
      req   = '0;
      lock  = '0;
      am[0] = 16'h0A00;
      am[1] = 16'h0B11;
      am[2] = 16'h1234;
      am[3] = 16'h0D33;
      for (int p = 0; p < 2; p++) begin
         mo[p] = -1;
         mp[p] = 0;
         mh[p] = 0;
      end

      //         rst   req      lock     gntA     gntB     wA wB addrInA   addrInB
      tab[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 16'h0000};
      tab[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 16'h0000};
      tab[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 16'h0000};
      tab[3]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 1, 1, 16'h0A00, 16'h0B11};
      tab[4]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 4'b1000, 1, 1, 16'h1234, 16'h0D33};
      tab[5]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 1, 1, 16'h0A00, 16'h0B11};
      tab[6]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 4'b1000, 1, 1, 16'h1234, 16'h0D33};
      tab[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 16'h0000};
      tab[8]  = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1, 0, 16'h1234, 16'h0000};
      tab[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 16'h0000};
      tab[10] = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 1, 0, 16'h0B11, 16'h0000};
      tab[11] = '{1'b1, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 0, 0, 16'h0B11, 16'h0000};
      tab[12] = '{1'b1, 4'b0101, 4'b0010, 4'b0010, 4'b0001, 0, 1, 16'h0B11, 16'h0A00};
      tab[13] = '{1'b1, 4'b0101, 4'b0010, 4'b0010, 4'b0100, 0, 1, 16'h0B11, 16'h1234};
      tab[14] = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1, 0, 16'h0D33, 16'h0000};
      tab[15] = '{1'b1, 4'b1111, 4'b1111, 4'b1000, 4'b0001, 1, 1, 16'h0D33, 16'h0A00};
      tab[16] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0, 0, 16'h0000, 16'h0000};
      tab[17] = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 1, 1, 16'h0A00, 16'h0B11};

      for (int r = 0; r < 18; r++) begin
         rst_n = tab[r].rst;
         req   = tab[r].rq;
         lock  = tab[r].lk;
         tick();
         chk($sformatf("table_row%0d", r), dut_v,
             {tab[r].ga, tab[r].gb, tab[r].wa, tab[r].wb, tab[r].aa, tab[r].ab,
              |(tab[r].ga | tab[r].gb)});
      end

      // Requester 0 locks A, requester 3 locks B, requester 2 waits for A.
      rst_n = 1'b0; req = '0; lock = '0;
      tick();
      rst_n = 1'b1; req = 4'b0001; lock = 4'b0001;
      tick();
      chk("tmo_grant0", {39'b0, gntA}, {39'b0, 4'b0001});
      req = 4'b1001; lock = 4'b1001;
      tick();
      chk("tmo_b3", {39'b0, gntB}, {39'b0, 4'b1000});
      for (int e = 3; e <= 12; e++) begin
         req  = 4'b1101;
         lock = (e >= 10) ? 4'b1000 : 4'b1001;
         tick();
         if (e <= 9)
            chk($sformatf("tmo_a_edge%0d", e), {39'b0, gntA},
                {39'b0, (TMO_ON && e == 9) ? 4'b0100 : 4'b0001});
         chk($sformatf("tmo_b_edge%0d", e), {39'b0, gntB}, {39'b0, 4'b1000});
         chk($sformatf("tmo_model%0d", e), dut_v, model_out());
      end

      // Random traffic: new inputs just after each edge, checked mid-cycle.
      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         req   = 4'($urandom_range(0, 15));
         lock  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         for (int i = 0; i < NREQ; i++)
            am[i] = 16'($urandom);
         #1;
         chk($sformatf("rand_out%0d", n), dut_v, model_out());
         chk($sformatf("rand_excl%0d", n), {39'b0, gntA & gntB}, 43'b0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
